// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake, registered results.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands around the same unsigned core.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_res;
    logic [WIDTH-1:0] rem_res;

    // The partial remainder stays below the divisor, so its (WIDTH+1)-th bit is always
    // zero between iterations; only the shifted trial value needs the extra bit.
    assign r_shift = {rem_q, dvd_q[WIDTH-1]};
    assign r_sub   = r_shift - {1'b0, dvs_q};
    assign q_bit   = ~r_sub[WIDTH];
    assign rem_d   = q_bit ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign quot_d  = {quot_q[WIDTH-2:0], q_bit};

`ifdef DIVIDER_SIGNED_EN
    logic neg_n_q;
    logic neg_d_q;

    assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Truncation toward zero: remainder follows the dividend's sign.
    assign quot_res = (neg_n_q ^ neg_d_q) ? -quot_d : quot_d;
    assign rem_res  = neg_n_q ? -rem_d : rem_d;
`else
    assign dvd_mag  = dividend;
    assign dvs_mag  = divisor;
    assign quot_res = quot_d;
    assign rem_res  = rem_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_n_q     <= 1'b0;
            neg_d_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quot_res;
                        remainder_q <= rem_res;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    if (start) begin
                        dvd_q  <= dvd_mag;
                        dvs_q  <= dvs_mag;
                        rem_q  <= '0;
                        quot_q <= '0;
                        cnt_q  <= '0;
`ifdef DIVIDER_SIGNED_EN
                        neg_n_q <= dividend[WIDTH-1];
                        neg_d_q <= divisor[WIDTH-1];
`endif
                        if (divisor != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
